// File: rtl/arb_prio_rr_4.sv
// rtl/arb_prio_rr_4.sv - 4-requester hold-until-release arbiter, fixed priority or round-robin
// Registered one-hot grant with encoded owner ID and an optional round-robin hold timeout.
module arb_prio_rr_4 #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       mode,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic {IDLE, BUSY} state_e;

  localparam bit               TO_EN    = (MAX_HOLD > 0);
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_TRG = CNT_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

  state_e           state_q, state_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       id_q, id_d;
  logic             to_q, to_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [1:0]       last_q, last_d;
  logic             rr_q, rr_d;

  logic [1:0] fp_win, rr_win, win, idx;
  logic       rr_found;
  logic       owner_req, others_req;

  always_comb begin
    fp_win = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (req[i]) fp_win = 2'(i);
    end
    // Scan starts just past the last owner so the previous winner ranks lowest.
    rr_win   = 2'd0;
    rr_found = 1'b0;
    idx      = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      idx = last_q + 2'(i);
      if (!rr_found && req[idx]) begin
        rr_win   = idx;
        rr_found = 1'b1;
      end
    end
    win = mode ? rr_win : fp_win;
  end

  assign owner_req  = |(req & gnt_q);
  assign others_req = |(req & ~gnt_q);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    id_d    = id_q;
    to_d    = 1'b0;
    hold_d  = hold_q;
    last_d  = last_q;
    rr_d    = rr_q;
    case (state_q)
      IDLE: begin
        if (en && (|req)) begin
          gnt_d   = 4'b0001 << win;
          id_d    = win;
          hold_d  = '0;
          last_d  = win;
          rr_d    = mode;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // Release and disable win over a coincident timeout.
        if (!en || !owner_req) begin
          gnt_d   = 4'b0000;
          id_d    = 2'd0;
          hold_d  = '0;
          state_d = IDLE;
        end else if (TO_EN && rr_q && (hold_q >= HOLD_TRG) && others_req) begin
          gnt_d   = 4'b0000;
          id_d    = 2'd0;
          hold_d  = '0;
          to_d    = 1'b1;
          state_d = IDLE;
        end else if (hold_q < HOLD_MAX) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= 4'b0000;
      id_q    <= 2'd0;
      to_q    <= 1'b0;
      hold_q  <= '0;
      last_q  <= 2'd3;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      to_q    <= to_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
      rr_q    <= rr_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = id_q;
  assign gnt_valid = |gnt_q;
  assign timeout   = to_q;

endmodule

// File: tb/tb_arb_prio_rr_4.sv
// tb/tb_arb_prio_rr_4.sv - directed self-checking bench for arb_prio_rr_4
module tb_arb_prio_rr_4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       mode = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  int total = 0;
  int bad   = 0;

  arb_prio_rr_4 #(.MAX_HOLD(4), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .req(req),
    .gnt(gnt), .gnt_id(gnt_id), .gnt_valid(gnt_valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  wire [7:0] obs = {gnt, gnt_id, gnt_valid, timeout};

  function automatic logic [7:0] expv(input logic [3:0] g, input logic to);
    logic [1:0] id;
    id = g[3] ? 2'd3 : g[2] ? 2'd2 : g[1] ? 2'd1 : 2'd0;
    return {g, id, |g, to};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en = 1'b0; mode = 1'b0; req = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    total++;
    if (obs !== 8'h00) begin
      bad++; $display("FAIL reset: got %b want %b", obs, 8'h00);
    end
    do_reset();
  endtask

  task automatic test_fixed();
    logic [3:0] g [6];
    logic [3:0] r [6];
    do_reset();
    en = 1'b1; mode = 1'b0;
    r = '{4'b0101, 4'b0001, 4'b0001, 4'b1110, 4'b1110, 4'b0000};
    g = '{4'b0100, 4'b0000, 4'b0001, 4'b0000, 4'b1000, 4'b0000};
    for (int i = 0; i < 6; i++) begin
      req = r[i];
      step();
      total++;
      if (obs !== expv(g[i], 1'b0)) begin
        bad++; $display("FAIL fixed[%0d]: got %b want %b", i, obs, expv(g[i], 1'b0));
      end
    end
  endtask

  task automatic test_rr_rotation();
    int order [5];
    order = '{0, 1, 2, 3, 0};
    do_reset();
    en = 1'b1; mode = 1'b1; req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < 2; c++) begin
        step();
        total++;
        if (obs !== expv(4'b0001 << order[k], 1'b0)) begin
          bad++; $display("FAIL rr_grant[%0d.%0d]: got %b want %b", k, c, obs, expv(4'b0001 << order[k], 1'b0));
        end
      end
      req[order[k]] = 1'b0;
      step();
      total++;
      if (obs !== 8'h00) begin
        bad++; $display("FAIL rr_gap[%0d]: got %b want %b", k, obs, 8'h00);
      end
      req = 4'b1111;
    end
  endtask

  task automatic test_timeout();
    logic [3:0] owner;
    do_reset();
    en = 1'b1; mode = 1'b1; req = 4'b0011;
    for (int r = 0; r < 3; r++) begin
      owner = (r % 2 == 0) ? 4'b0001 : 4'b0010;
      for (int c = 0; c < 4; c++) begin
        step();
        total++;
        if (obs !== expv(owner, 1'b0)) begin
          bad++; $display("FAIL timeout_hold[%0d.%0d]: got %b want %b", r, c, obs, expv(owner, 1'b0));
        end
      end
      step();
      total++;
      if (obs !== expv(4'b0000, 1'b1)) begin
        bad++; $display("FAIL timeout_pulse[%0d]: got %b want %b", r, obs, expv(4'b0000, 1'b1));
      end
    end
  endtask

  task automatic test_no_contention();
    do_reset();
    en = 1'b1; mode = 1'b1; req = 4'b1000;
    for (int c = 0; c < 20; c++) begin
      step();
      total++;
      if (obs !== expv(4'b1000, 1'b0)) begin
        bad++; $display("FAIL solo[%0d]: got %b want %b", c, obs, expv(4'b1000, 1'b0));
      end
    end
  endtask

  task automatic test_enable();
    logic       e [5];
    logic [3:0] g [5];
    do_reset();
    mode = 1'b0; req = 4'b0010;
    e = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    g = '{4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0010};
    for (int i = 0; i < 5; i++) begin
      en = e[i];
      step();
      total++;
      if (obs !== expv(g[i], 1'b0)) begin
        bad++; $display("FAIL enable[%0d]: got %b want %b", i, obs, expv(g[i], 1'b0));
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    en = 1'b1; mode = 1'b0; req = 4'b0100;
    step();
    total++;
    if (obs !== expv(4'b0100, 1'b0)) begin
      bad++; $display("FAIL areset_pre: got %b want %b", obs, expv(4'b0100, 1'b0));
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (obs !== 8'h00) begin
      bad++; $display("FAIL areset_clear: got %b want %b", obs, 8'h00);
    end
    req = 4'b1111; mode = 1'b1;
    #2;
    rst_n = 1'b1;
    step();
    total++;
    if (obs !== expv(4'b0001, 1'b0)) begin
      bad++; $display("FAIL areset_first: got %b want %b", obs, expv(4'b0001, 1'b0));
    end
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_rr_rotation();
    test_timeout();
    test_no_contention();
    test_enable();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/arb_prio_rr_4.md
Name: arb_prio_rr_4

Overview:
- 4-requester arbiter that shares one downstream resource between four requesters and holds ownership until release.
- Selects owner by fixed priority (req[3] highest … req[0] lowest) or by round-robin, per mode input.
- Registered one-hot grant plus 2-bit encoded owner ID; optional hold-timeout enforces fairness in round-robin mode.

Parameters:
MAX_HOLD, 16, max consecutive grant cycles in round-robin mode before forced revoke; 0 disables timeout
CNT_W, 5, width of hold counter; must satisfy 2^CNT_W > MAX_HOLD

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  arbiter enable; 0 blocks new grants and revokes current grant
mode  input  1  0 = fixed priority, 1 = round-robin; sampled only in IDLE
req  input  4  level requests; requester holds high for duration of its use
gnt  output  4  registered one-hot grant, all-zero when no owner
gnt_id  output  2  encoded index of current owner; 0 when gnt_valid=0
gnt_valid  output  1  high while any gnt bit is high
timeout  output  1  one-cycle pulse on forced revoke

Behaviour:
- Reset (rst_n=0, async): state=IDLE, gnt=0, gnt_id=0, gnt_valid=0, timeout=0, hold_cnt=0, last=3 (RR search starts at 0). Deassertion takes effect at the next clk edge.
- States: IDLE, BUSY.
- IDLE, en=1, req!=0: winner chosen combinationally, registered at the edge.
  - Next cycle: gnt=onehot(winner), gnt_id=winner, gnt_valid=1, hold_cnt=0, state=BUSY.
  - Latency: req sampled high at edge N -> gnt high after edge N.
- Fixed mode: winner = highest set req index.
- RR mode: winner = first set req scanning last+1, last+2, … mod 4.
- On every grant, last<=winner (both modes).
- IDLE with en=0 or req=0: outputs stay 0.
- BUSY release: req[owner]=0 at an edge -> gnt/gnt_id/gnt_valid cleared at that edge, state=IDLE.
  - Mandatory one-cycle dead gap between consecutive grants; new arbitration happens from IDLE on the following edge.
- BUSY hold: while req[owner]=1, grant held; hold_cnt increments each cycle, saturating at MAX_HOLD.
  - Other req bits are ignored; no preemption in fixed mode.
- Timeout, RR mode only, MAX_HOLD>0:
  - Trigger: hold_cnt==MAX_HOLD-1 and any other req bit set at an edge.
  - Action: gnt cleared, timeout=1 for exactly that cycle, state=IDLE.
  - Next arbitration starts from last+1, so the revoked owner ranks lowest.
  - If no other requester is pending, the grant continues and hold_cnt saturates.
- en=0 in BUSY: gnt cleared at next edge, state=IDLE, timeout stays 0, last unchanged.
- Release and timeout conditions true on the same edge: treat as release; timeout=0.
- mode changes while BUSY take effect only at the next IDLE arbitration.
- Invariants: gnt is always one-hot or zero; gnt_valid==|gnt; gnt_id consistent with gnt.
- Reset asserted mid-grant: all outputs clear immediately, without waiting for clk.

Test Plan:
- Fixed priority: mode=0, en=1, req=4'b0101 from IDLE -> after 1 edge gnt=4'b0100, gnt_id=2. Drop req[2] -> gnt=0 for 1 cycle, then gnt=4'b0001, gnt_id=0.
- Round-robin rotation: mode=1, req=4'b1111 held, each owner drops req for 1 cycle after 2 cycles of grant -> grant order 0,1,2,3,0 with 1 dead cycle between grants.
- Timeout: mode=1, MAX_HOLD=4, req=4'b0011 held constantly -> gnt=0001 for 4 cycles, timeout pulse 1 cycle with gnt=0, then gnt=0010 for 4 cycles. Repeats alternating.
- No contention: mode=1, MAX_HOLD=4, req=4'b1000 only for 20 cycles -> gnt=1000 continuous, timeout never asserts.
- Enable gating: grant active on req[1], en dropped -> gnt=0 next edge, timeout=0. en restored with req=4'b0010 -> gnt=0010 after 1 edge.
- Async reset: assert rst_n=0 mid-BUSY between clk edges -> gnt, gnt_id, gnt_valid, timeout read 0 immediately. After release with req=4'b1111, mode=1 -> first grant is req[0].
